// File: rtl/segment_time_reader.sv
// Receive-side monitor for the four 7-segment digit buses: glitch filter, BCD decode, time
// classification and serial snapshot readout. Define SEGREAD_PARITY_EN for a 17-bit frame with even parity.
module segment_time_reader #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [6:0]           segment_hxxx_i,
   input  logic [6:0]           segment_xhxx_i,
   input  logic [6:0]           segment_xxmx_i,
   input  logic [6:0]           segment_xxxm_i,
   input  logic                 rd_req_i,
   output logic [3:0]           val_hxxx_o,
   output logic [3:0]           val_xhxx_o,
   output logic [3:0]           val_xxmx_o,
   output logic [3:0]           val_xxxm_o,
   output logic                 time_valid_o,
   output logic                 tick_1m_o,
   output logic                 jump_o,
   output logic                 code_err_o,
   output logic                 range_err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   output logic                 ser_data_o,
   output logic                 ser_frame_o
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef SEGREAD_PARITY_EN
   localparam int unsigned FRAME_W = 17;
`else
   localparam int unsigned FRAME_W = 16;
`endif
   localparam int unsigned BIT_W = $clog2(FRAME_W);

   typedef enum logic {IDLE, SHIFT} state_t;

   // {legal, bcd} for one segment pattern
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'h3F:   seg_decode = {1'b1, 4'd0};
         7'h06:   seg_decode = {1'b1, 4'd1};
         7'h5B:   seg_decode = {1'b1, 4'd2};
         7'h4F:   seg_decode = {1'b1, 4'd3};
         7'h66:   seg_decode = {1'b1, 4'd4};
         7'h6D:   seg_decode = {1'b1, 4'd5};
         7'h7D:   seg_decode = {1'b1, 4'd6};
         7'h07:   seg_decode = {1'b1, 4'd7};
         7'h7F:   seg_decode = {1'b1, 4'd8};
         7'h6F:   seg_decode = {1'b1, 4'd9};
         default: seg_decode = 5'd0;
      endcase
   endfunction

   logic [27:0]          sample_q, sample_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [15:0]          digits_q, digits_d;
   logic                 valid_q, valid_d;
   logic                 tick_q, tick_d;
   logic                 jump_q, jump_d;
   logic                 cerr_q, cerr_d;
   logic                 rerr_q, rerr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   shreg_q, shreg_d;
   logic [BIT_W-1:0]     bcnt_q, bcnt_d;
   logic                 sdata_q, sdata_d;
   logic                 sframe_q, sframe_d;

   logic [27:0]        seg_in;
   logic               accept;
   logic [4:0]         dec_h, dec_xh, dec_m, dec_xm;
   logic [15:0]        new_time, inc_time;
   logic               codes_ok, in_range;
   logic [FRAME_W-1:0] snap;

   always_comb begin
      sample_d  = sample_q;
      cnt_d     = cnt_q;
      digits_d  = digits_q;
      valid_d   = valid_q;
      tick_d    = 1'b0;
      jump_d    = 1'b0;
      cerr_d    = 1'b0;
      rerr_d    = 1'b0;
      err_cnt_d = err_cnt_q;
      state_d   = state_q;
      shreg_d   = shreg_q;
      bcnt_d    = bcnt_q;
      sdata_d   = 1'b0;
      sframe_d  = 1'b0;

      // Stability filter: count identical consecutive samples, accept once on reaching the limit
      seg_in   = {segment_hxxx_i, segment_xhxx_i, segment_xxmx_i, segment_xxxm_i};
      sample_d = seg_in;
      if (seg_in != sample_q)
         cnt_d = '0;
      else if (cnt_q != CNT_W'(STABLE_CYCLES))
         cnt_d = cnt_q + CNT_W'(1);
      accept = (cnt_q != CNT_W'(STABLE_CYCLES)) && (cnt_d == CNT_W'(STABLE_CYCLES));

      dec_h    = seg_decode(sample_q[27:21]);
      dec_xh   = seg_decode(sample_q[20:14]);
      dec_m    = seg_decode(sample_q[13:7]);
      dec_xm   = seg_decode(sample_q[6:0]);
      new_time = {dec_h[3:0], dec_xh[3:0], dec_m[3:0], dec_xm[3:0]};
      codes_ok = dec_h[4] & dec_xh[4] & dec_m[4] & dec_xm[4];
      in_range = !((dec_h[3:0] > 4'd2) || (dec_m[3:0] > 4'd5) ||
                   ((dec_h[3:0] == 4'd2) && (dec_xh[3:0] > 4'd3)));

      // Current time plus one minute, with BCD carries and midnight wrap
      if (digits_q[3:0] != 4'd9)
         inc_time = {digits_q[15:4], digits_q[3:0] + 4'd1};
      else if (digits_q[7:4] != 4'd5)
         inc_time = {digits_q[15:8], digits_q[7:4] + 4'd1, 4'd0};
      else if (digits_q[15:8] == 8'h23)
         inc_time = 16'h0000;
      else if (digits_q[11:8] == 4'd9)
         inc_time = {digits_q[15:12] + 4'd1, 12'h000};
      else
         inc_time = {digits_q[15:12], digits_q[11:8] + 4'd1, 8'h00};

      if (accept) begin
         if (!codes_ok || !in_range) begin
            cerr_d = !codes_ok;
            rerr_d = codes_ok;
            if (err_cnt_q != '1)
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         end else begin
            digits_d = new_time;
            valid_d  = 1'b1;
            if (valid_q && (new_time == inc_time))
               tick_d = 1'b1;
            else if (valid_q && (new_time != digits_q))
               jump_d = 1'b1;
         end
      end

`ifdef SEGREAD_PARITY_EN
      snap = {digits_q, ^digits_q};
`else
      snap = digits_q;
`endif

      // Serial snapshot: first bit driven on the request edge, then one bit per cycle
      case (state_q)
         IDLE: begin
            if (rd_req_i && valid_q) begin
               state_d  = SHIFT;
               sframe_d = 1'b1;
               sdata_d  = snap[FRAME_W-1];
               shreg_d  = {snap[FRAME_W-2:0], 1'b0};
               bcnt_d   = BIT_W'(FRAME_W - 1);
            end
         end
         SHIFT: begin
            if (bcnt_q != '0) begin
               sframe_d = 1'b1;
               sdata_d  = shreg_q[FRAME_W-1];
               shreg_d  = {shreg_q[FRAME_W-2:0], 1'b0};
               bcnt_d   = bcnt_q - BIT_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sample_q  <= '0;
         cnt_q     <= '0;
         digits_q  <= '0;
         valid_q   <= 1'b0;
         tick_q    <= 1'b0;
         jump_q    <= 1'b0;
         cerr_q    <= 1'b0;
         rerr_q    <= 1'b0;
         err_cnt_q <= '0;
         state_q   <= IDLE;
         shreg_q   <= '0;
         bcnt_q    <= '0;
         sdata_q   <= 1'b0;
         sframe_q  <= 1'b0;
      end else begin
         sample_q  <= sample_d;
         cnt_q     <= cnt_d;
         digits_q  <= digits_d;
         valid_q   <= valid_d;
         tick_q    <= tick_d;
         jump_q    <= jump_d;
         cerr_q    <= cerr_d;
         rerr_q    <= rerr_d;
         err_cnt_q <= err_cnt_d;
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bcnt_q    <= bcnt_d;
         sdata_q   <= sdata_d;
         sframe_q  <= sframe_d;
      end
   end

   assign val_hxxx_o   = digits_q[15:12];
   assign val_xhxx_o   = digits_q[11:8];
   assign val_xxmx_o   = digits_q[7:4];
   assign val_xxxm_o   = digits_q[3:0];
   assign time_valid_o = valid_q;
   assign tick_1m_o    = tick_q;
   assign jump_o       = jump_q;
   assign code_err_o   = cerr_q;
   assign range_err_o  = rerr_q;
   assign err_cnt_o    = err_cnt_q;
   assign ser_data_o   = sdata_q;
   assign ser_frame_o  = sframe_q;

endmodule

// File: tb/tb_segment_time_reader.sv
// Bench for segment_time_reader: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a minute-arithmetic reference model.
module tb_segment_time_reader;

   localparam int unsigned STAB = 4;
   localparam int unsigned EW   = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [6:0]    s_h, s_xh, s_m, s_xm;
   logic          rd_req;
   logic [3:0]    v_h, v_xh, v_m, v_xm;
   logic          time_valid, tick, jump, cerr, rerr, ser_data, ser_frame;
   logic [EW-1:0] err_cnt;

   always #5 clk = ~clk;

   segment_time_reader #(.STABLE_CYCLES(STAB), .ERR_CNT_W(EW)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .segment_hxxx_i(s_h), .segment_xhxx_i(s_xh), .segment_xxmx_i(s_m), .segment_xxxm_i(s_xm),
      .rd_req_i(rd_req),
      .val_hxxx_o(v_h), .val_xhxx_o(v_xh), .val_xxmx_o(v_m), .val_xxxm_o(v_xm),
      .time_valid_o(time_valid), .tick_1m_o(tick), .jump_o(jump),
      .code_err_o(cerr), .range_err_o(rerr), .err_cnt_o(err_cnt),
      .ser_data_o(ser_data), .ser_frame_o(ser_frame)
   );

   int errors = 0;
   int checks = 0;
   logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int decode(input logic [6:0] s);
      for (int i = 0; i < 10; i++)
         if (s == codes[i]) return i;
      return -1;
   endfunction

   // Reference model: times as minutes-of-day, serial frame as a bit queue
   int          m_d [4];
   int          dg [4];
   bit          m_valid, m_tick, m_jump, m_cerr, m_rerr, m_data, m_frame;
   int          m_err;
   logic [27:0] prev_in, cur_in;
   int          run;
   bit          bitq [$];
   logic [15:0] m_snap;
   bit          chk_en = 1'b0;
   int          t_new, t_old;

   always @(posedge clk) begin
      chk_en = 1'b1;
      if (!rstn) begin
         for (int i = 0; i < 4; i++) m_d[i] = 0;
         {m_valid, m_tick, m_jump, m_cerr, m_rerr, m_data, m_frame} = '0;
         m_err   = 0;
         prev_in = '0;
         run     = 1;
         bitq.delete();
      end else begin
         cur_in = {s_h, s_xh, s_m, s_xm};
         if (cur_in == prev_in) begin
            if (run < 1000) run++;
         end else run = 1;
         prev_in = cur_in;
         if (rd_req && m_valid && !m_frame) begin
            m_snap = {4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3])};
            for (int i = 15; i >= 0; i--) bitq.push_back(m_snap[i]);
`ifdef SEGREAD_PARITY_EN
            bitq.push_back(^m_snap);
`endif
         end
         if (bitq.size() > 0) begin
            m_data  = bitq.pop_front();
            m_frame = 1'b1;
         end else begin
            m_data  = 1'b0;
            m_frame = 1'b0;
         end
         {m_tick, m_jump, m_cerr, m_rerr} = '0;
         if (run == STAB + 1) begin
            dg[0] = decode(s_h); dg[1] = decode(s_xh); dg[2] = decode(s_m); dg[3] = decode(s_xm);
            if (dg[0] < 0 || dg[1] < 0 || dg[2] < 0 || dg[3] < 0) begin
               m_cerr = 1'b1;
               if (m_err < 255) m_err++;
            end else if (dg[0] * 10 + dg[1] > 23 || dg[2] > 5) begin
               m_rerr = 1'b1;
               if (m_err < 255) m_err++;
            end else begin
               t_new = (dg[0] * 10 + dg[1]) * 60 + dg[2] * 10 + dg[3];
               t_old = (m_d[0] * 10 + m_d[1]) * 60 + m_d[2] * 10 + m_d[3];
               if (m_valid) begin
                  if (t_new == (t_old + 1) % 1440) m_tick = 1'b1;
                  else if (t_new != t_old) m_jump = 1'b1;
               end
               m_d     = dg;
               m_valid = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("val_hxxx", int'(v_h), m_d[0]);
         check("val_xhxx", int'(v_xh), m_d[1]);
         check("val_xxmx", int'(v_m), m_d[2]);
         check("val_xxxm", int'(v_xm), m_d[3]);
         check("time_valid", int'(time_valid), int'(m_valid));
         check("tick_1m", int'(tick), int'(m_tick));
         check("jump", int'(jump), int'(m_jump));
         check("code_err", int'(cerr), int'(m_cerr));
         check("range_err", int'(rerr), int'(m_rerr));
         check("err_cnt", int'(err_cnt), m_err);
         check("ser_frame", int'(ser_frame), int'(m_frame));
         check("ser_data", int'(ser_data), int'(m_data));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_digits(input int a, input int b, input int c, input int d);
      s_h = codes[a]; s_xh = codes[b]; s_m = codes[c]; s_xm = codes[d];
   endtask

   task automatic set_min(input int t);
      set_digits((t / 60) / 10, (t / 60) % 10, (t % 60) / 10, (t % 60) % 10);
   endtask

   task automatic check_vals(input string name, input int a, input int b, input int c, input int d);
      check(name, int'({v_h, v_xh, v_m, v_xm}), (a << 12) | (b << 8) | (c << 4) | d);
   endtask

   logic [15:0] exp16;
   int          cur, r, n;

   initial begin
      rstn = 1'b0; rd_req = 1'b0;
      set_digits(1, 2, 3, 4);
      step(2);
      check("reset_valid", int'(time_valid), 0);
      check_vals("reset_vals", 0, 0, 0, 0);
      check("reset_frame", int'(ser_frame), 0);

      rstn = 1'b1;
      step(4);
      check("pre_accept_valid", int'(time_valid), 0);
      step(1);
      check_vals("first_vals", 1, 2, 3, 4);
      check("first_valid", int'(time_valid), 1);
      check("first_tick", int'(tick), 0);
      check("first_jump", int'(jump), 0);

      set_digits(1, 2, 3, 5); step(5);
      check("tick_1235", int'(tick), 1);
      step(1);
      check("tick_one_cycle", int'(tick), 0);
      set_digits(2, 3, 5, 9); step(5);
      check("jump_2359", int'(jump), 1);
      set_digits(0, 0, 0, 0); step(5);
      check("tick_midnight", int'(tick), 1);
      set_digits(0, 9, 5, 9); step(5);
      set_digits(1, 0, 0, 0); step(5);
      check("tick_0959", int'(tick), 1);
      set_digits(1, 2, 3, 4); step(5);
      set_digits(1, 3, 3, 4); step(5);
      check("jump_1334", int'(jump), 1);
      set_digits(1, 2, 3, 4); step(5);

      set_digits(8, 8, 8, 8); step(1);
      for (int i = 0; i < 9; i++) begin
         if (i == 3) set_digits(1, 2, 3, 4);
         check("glitch_tick", int'(tick), 0);
         check("glitch_jump", int'(jump), 0);
         check_vals("glitch_vals", 1, 2, 3, 4);
         step(1);
      end

      set_digits(1, 2, 3, 4); s_xm = 7'h00; step(5);
      check("blank_code_err", int'(cerr), 1);
      check("blank_err_cnt", int'(err_cnt), 1);
      set_digits(2, 5, 0, 0); step(5);
      check("range_err", int'(rerr), 1);
      check("range_err_cnt", int'(err_cnt), 2);
      check_vals("range_vals_kept", 1, 2, 3, 4);
      set_digits(1, 2, 3, 4); step(5);

      exp16 = 16'h1234;
      rd_req = 1'b1; step(1); rd_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("frame_bit", int'(ser_frame), 1);
         check("data_bit", int'(ser_data), int'(exp16[15 - i]));
         rd_req = (i == 4);
         step(1);
      end
      rd_req = 1'b0;
`ifdef SEGREAD_PARITY_EN
      check("parity_frame", int'(ser_frame), 1);
      check("parity_bit", int'(ser_data), 1);
      step(1);
`endif
      check("frame_end", int'(ser_frame), 0);
      check("frame_end_data", int'(ser_data), 0);

      step(1);
      rd_req = 1'b1; step(1); rd_req = 1'b0;
      step(3);
      rstn = 1'b0; step(1);
      check("rst_mid_frame", int'(ser_frame), 0);
      check("rst_mid_data", int'(ser_data), 0);
      check("rst_mid_valid", int'(time_valid), 0);
      check("rst_mid_errcnt", int'(err_cnt), 0);
      rstn = 1'b1;

      cur = 12 * 60 + 34;
      for (int sg = 0; sg < 400; sg++) begin
         r = int'($urandom_range(0, 99));
         if (r < 40) begin
            cur = (cur + 1) % 1440; set_min(cur);
         end else if (r < 60) begin
            cur = int'($urandom_range(0, 1439)); set_min(cur);
         end else if (r < 70) begin
            set_digits(int'($urandom_range(2, 9)), int'($urandom_range(0, 9)),
                       int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
         end else if (r < 80) begin
            set_min(cur); s_xm = 7'($urandom_range(0, 127));
         end
         n = int'($urandom_range(1, 8));
         for (int k = 0; k < n; k++) begin
            rd_req = ($urandom_range(0, 9) == 0);
            rstn   = ($urandom_range(0, 199) != 0);
            step(1);
         end
         rd_req = 1'b0; rstn = 1'b1;
      end
      step(25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
